// File: rtl/buffer_interconnect_v4_pkg.sv
// Shared types and sizing for the buffer RAM interconnect.
// Route codes: values below the port count select a source; anything else turns the destination off.
package buffer_interconnect_v4_pkg;
    localparam int ICN_E        = 2;
    localparam int ICN_FSIZE    = 16;
    localparam int DATA_W       = ICN_E * ICN_FSIZE;
    localparam int ADDR_W       = 32;
    localparam int ICN_PORT_NUM = 4;
    localparam int ICN_STAGES   = $clog2(ICN_PORT_NUM);
    localparam int ICN_SEL_W    = ICN_STAGES + 1;

    typedef logic [ICN_SEL_W-1:0] route_t;

    typedef enum logic [1:0] {RUN, DRAIN, SWAP} icn_state_t;

    typedef struct packed {
        logic              wren;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] raddr;
    } buffer_ram_inputs_t;
endpackage

// File: rtl/buffer_interconnect_v4_icn_mux_tree.sv
// One destination of the crossbar: a log2 mux tree whose select copy rides with each beat,
// with an optional register after every stage (PIPE_MASK bit i registers stage i).
module buffer_interconnect_v4_icn_mux_tree #(
    parameter int                  WIDTH     = 8,
    parameter int                  N         = 4,
    parameter int                  STAGES    = $clog2(N),
    parameter logic [STAGES-1:0]   PIPE_MASK = '1,
    parameter int                  SEL_W     = STAGES + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0][WIDTH-1:0]   data_in,
    input  logic [N-1:0]              vld_in,
    input  logic [SEL_W-1:0]          sel,
    output logic                      launch,
    output logic                      vld_out,
    output logic [WIDTH-1:0]          data_out
);
    localparam int NP = 1 << STAGES;

    logic route_ok;
    // N never exceeds 2**STAGES, so every code with the MSB set also fails this compare.
    assign route_ok = (sel < SEL_W'(N));

    for (genvar l = 0; l <= STAGES; l++) begin : g_lv
        localparam int CNT = NP >> l;
        logic [CNT-1:0]            v;
        logic [CNT-1:0][WIDTH-1:0] d;
        logic [SEL_W-1:0]          s;
        logic                      en;

        if (l == 0) begin : g_leaf
            for (genvar j = 0; j < NP; j++) begin : g_in
                if (j < N) begin : g_live
                    assign v[j] = vld_in[j];
                    assign d[j] = data_in[j];
                end else begin : g_tie
                    assign v[j] = 1'b0;
                    assign d[j] = '0;
                end
            end
            assign s  = sel;
            assign en = route_ok;
        end else begin : g_node
            logic [CNT-1:0]            v_c;
            logic [CNT-1:0][WIDTH-1:0] d_c;
            always_comb begin
                v_c = '0;
                d_c = '0;
                for (int j = 0; j < CNT; j++) begin
                    v_c[j] = g_lv[l-1].s[l-1] ? g_lv[l-1].v[2*j+1] : g_lv[l-1].v[2*j];
                    d_c[j] = g_lv[l-1].s[l-1] ? g_lv[l-1].d[2*j+1] : g_lv[l-1].d[2*j];
                end
            end
            if (PIPE_MASK[l-1]) begin : g_reg
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        v  <= '0;
                        d  <= '0;
                        s  <= '0;
                        en <= 1'b0;
                    end else begin
                        v  <= v_c;
                        d  <= d_c;
                        s  <= g_lv[l-1].s;
                        en <= g_lv[l-1].en;
                    end
                end
            end else begin : g_wire
                assign v  = v_c;
                assign d  = d_c;
                assign s  = g_lv[l-1].s;
                assign en = g_lv[l-1].en;
            end
        end
    end

    assign launch   = route_ok & g_lv[0].v[sel[STAGES-1:0]];
    assign vld_out  = g_lv[STAGES].v[0] & g_lv[STAGES].en;
    assign data_out = g_lv[STAGES].en ? g_lv[STAGES].d[0] : '0;
endmodule

// File: rtl/buffer_interconnect_v4.sv
// Crossbar between compute modules and buffer RAM banks: request path and read path,
// a registered route table and a drain-before-swap reconfiguration FSM.
module buffer_interconnect_v4
    import buffer_interconnect_v4_pkg::*;
#(
    parameter int                          PORT_NUM  = ICN_PORT_NUM,
    parameter logic [$clog2(PORT_NUM)-1:0] PIPE_MASK = '1,
    localparam int                         SEL_W     = $clog2(PORT_NUM) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  buffer_ram_inputs_t [PORT_NUM-1:0]    req_in,
    input  logic [PORT_NUM-1:0]                  req_vld_in,
    output buffer_ram_inputs_t [PORT_NUM-1:0]    req_out,
    output logic [PORT_NUM-1:0]                  req_vld_out,
    input  logic [PORT_NUM-1:0][DATA_W-1:0]      rd_in,
    input  logic [PORT_NUM-1:0]                  rd_vld_in,
    output logic [PORT_NUM-1:0][DATA_W-1:0]      rd_out,
    output logic [PORT_NUM-1:0]                  rd_vld_out,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [PORT_NUM-1:0][SEL_W-1:0]       cfg_wsel,
    input  logic [PORT_NUM-1:0][SEL_W-1:0]       cfg_rsel,
    output logic                                 quiesce,
    output logic                                 busy,
    output logic                                 sel_err,
    output icn_state_t                           dbg_state
);
    localparam int STAGES = $clog2(PORT_NUM);
    localparam int L      = $countones(PIPE_MASK);
    localparam int CNT_W  = $clog2(2 * PORT_NUM * (L + 1)) + 1;
    localparam int REQ_W  = $bits(buffer_ram_inputs_t);
    localparam logic [SEL_W-1:0] ROUTE_OFF = {1'b1, {(SEL_W-1){1'b0}}};

    // Config handshake: cfg_valid is held by the requester until cfg_ready, which pulses for
    // exactly one cycle when the table captured at cfg_valid's first cycle goes live.
    icn_state_t                    state;
    logic [PORT_NUM-1:0][SEL_W-1:0] wsel_tab, rsel_tab, wsel_pend, rsel_pend;
    logic [PORT_NUM-1:0]           launch_w, launch_r;
    logic [PORT_NUM-1:0][REQ_W-1:0] req_flat, req_pay;
    logic [CNT_W-1:0]              cnt, inc, dec;

    assign req_flat  = req_in;
    assign dbg_state = state;
    assign busy      = (cnt != '0);

    for (genvar k = 0; k < PORT_NUM; k++) begin : g_dst
        buffer_interconnect_v4_icn_mux_tree #(
            .WIDTH(REQ_W), .N(PORT_NUM), .STAGES(STAGES), .PIPE_MASK(PIPE_MASK), .SEL_W(SEL_W)
        ) u_req_tree (
            .clk(clk), .rst(rst), .data_in(req_flat), .vld_in(req_vld_in), .sel(wsel_tab[k]),
            .launch(launch_w[k]), .vld_out(req_vld_out[k]), .data_out(req_pay[k])
        );
        buffer_interconnect_v4_icn_mux_tree #(
            .WIDTH(DATA_W), .N(PORT_NUM), .STAGES(STAGES), .PIPE_MASK(PIPE_MASK), .SEL_W(SEL_W)
        ) u_rd_tree (
            .clk(clk), .rst(rst), .data_in(rd_in), .vld_in(rd_vld_in), .sel(rsel_tab[k]),
            .launch(launch_r[k]), .vld_out(rd_vld_out[k]), .data_out(rd_out[k])
        );
    end

    always_comb begin
        buffer_ram_inputs_t p;
        req_out = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            p          = req_pay[k];
            p.wren     = p.wren & req_vld_out[k];
            req_out[k] = p;
        end
    end

    // Beats are counted per destination, so a broadcast adds one per selecting destination.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            inc = inc + CNT_W'(launch_w[k]) + CNT_W'(launch_r[k]);
            dec = dec + CNT_W'(req_vld_out[k]) + CNT_W'(rd_vld_out[k]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt + inc - dec;
    end

    // Only the canonical off code is silent; any other code at or above PORT_NUM is flagged.
    function automatic logic route_bad(input logic [PORT_NUM-1:0][SEL_W-1:0] tab);
        route_bad = 1'b0;
        for (int k = 0; k < PORT_NUM; k++)
            if (tab[k] >= SEL_W'(PORT_NUM) && tab[k] != ROUTE_OFF) route_bad = 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            quiesce   <= 1'b0;
            cfg_ready <= 1'b0;
            sel_err   <= 1'b0;
            wsel_tab  <= {PORT_NUM{ROUTE_OFF}};
            rsel_tab  <= {PORT_NUM{ROUTE_OFF}};
            wsel_pend <= {PORT_NUM{ROUTE_OFF}};
            rsel_pend <= {PORT_NUM{ROUTE_OFF}};
        end else begin
            case (state)
                RUN: if (cfg_valid) begin
                    wsel_pend <= cfg_wsel;
                    rsel_pend <= cfg_rsel;
                    quiesce   <= 1'b1;
                    state     <= DRAIN;
                end
                DRAIN: if (!busy && !(|req_vld_in) && !(|rd_vld_in)) begin
                    cfg_ready <= 1'b1;
                    state     <= SWAP;
                end
                SWAP: begin
                    wsel_tab  <= wsel_pend;
                    rsel_tab  <= rsel_pend;
                    sel_err   <= sel_err | route_bad(wsel_pend) | route_bad(rsel_pend);
                    cfg_ready <= 1'b0;
                    quiesce   <= 1'b0;
                    state     <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_buffer_interconnect_v4.sv
// Randomised scoreboard bench for buffer_interconnect_v4 (PORT_NUM=4, two pipeline stages).
module tb_buffer_interconnect_v4;
  import buffer_interconnect_v4_pkg::*;

  localparam int P  = 4;
  localparam int L  = 2;
  localparam int SW = 3;
  localparam int RW = $bits(buffer_ram_inputs_t);

  logic clk = 1'b0;
  logic rst;
  buffer_ram_inputs_t [P-1:0] req_in, req_out;
  logic [P-1:0] req_vld_in, req_vld_out, rd_vld_in, rd_vld_out;
  logic [P-1:0][DATA_W-1:0] rd_in, rd_out;
  logic cfg_valid, cfg_ready, quiesce, busy, sel_err;
  logic [P-1:0][SW-1:0] cfg_wsel, cfg_rsel;
  icn_state_t dbg_state;

  buffer_interconnect_v4 #(.PORT_NUM(P), .PIPE_MASK(2'b11)) dut (
    .clk(clk), .rst(rst),
    .req_in(req_in), .req_vld_in(req_vld_in), .req_out(req_out), .req_vld_out(req_vld_out),
    .rd_in(rd_in), .rd_vld_in(rd_vld_in), .rd_out(rd_out), .rd_vld_out(rd_vld_out),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_wsel(cfg_wsel), .cfg_rsel(cfg_rsel),
    .quiesce(quiesce), .busy(busy), .sel_err(sel_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  route_t mw[P], mr[P];      // model route tables currently live
  route_t nw[P], nr[P];      // tables to offer on the next reconfiguration
  // entry: [127:120]=destination, [119:104]=due cycle, [RW-1:0]=payload
  logic [127:0] req_q[$];
  logic [127:0] rd_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference: destination d receives source r's beat L cycles later iff r < P and r is valid.
  task automatic push_expect();
    logic [127:0] e;
    for (int d = 0; d < P; d++) begin
      if (mw[d] < route_t'(P) && req_vld_in[mw[d][1:0]]) begin
        e = '0;
        e[127:120] = 8'(d);
        e[119:104] = 16'(cyc + L);
        e[RW-1:0]  = req_in[mw[d][1:0]];
        req_q.push_back(e);
      end
    end
    for (int d = 0; d < P; d++) begin
      if (mr[d] < route_t'(P) && rd_vld_in[mr[d][1:0]]) begin
        e = '0;
        e[127:120] = 8'(d);
        e[119:104] = 16'(cyc + L);
        e[DATA_W-1:0] = rd_in[mr[d][1:0]];
        rd_q.push_back(e);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [127:0] e;
    if (!rst) begin
      for (int d = 0; d < P; d++) begin
        if (req_vld_out[d]) begin
          if (req_q.size() == 0) fail_now($sformatf("req_extra_beat dest %0d", d));
          else begin
            e = req_q.pop_front();
            check("req_dest", 128'(d), 128'(e[127:120]));
            check("req_latency", 128'(cyc), 128'(e[119:104]));
            check("req_payload", 128'(req_out[d]), 128'(e[RW-1:0]));
          end
        end else begin
          check("req_wren_gated", 128'(req_out[d].wren), 128'(0));
        end
      end
      for (int d = 0; d < P; d++) begin
        if (rd_vld_out[d]) begin
          if (rd_q.size() == 0) fail_now($sformatf("rd_extra_beat dest %0d", d));
          else begin
            e = rd_q.pop_front();
            check("rd_dest", 128'(d), 128'(e[127:120]));
            check("rd_latency", 128'(cyc), 128'(e[119:104]));
            check("rd_data", 128'(rd_out[d]), 128'(e[DATA_W-1:0]));
          end
        end
      end
      while (req_q.size() > 0 && int'(req_q[0][119:104]) <= cyc) begin
        fail_now($sformatf("req_missing_beat dest %0d", req_q[0][127:120]));
        void'(req_q.pop_front());
      end
      while (rd_q.size() > 0 && int'(rd_q[0][119:104]) <= cyc) begin
        fail_now($sformatf("rd_missing_beat dest %0d", rd_q[0][127:120]));
        void'(rd_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      req_vld_in = '0;
      rd_vld_in  = '0;
    end
  endtask

  task automatic rand_cycle(input logic [P-1:0] rqv, input logic [P-1:0] rdv);
    tick();
    for (int s = 0; s < P; s++) begin
      req_in[s].wren  = 1'($urandom_range(0, 1));
      req_in[s].waddr = $urandom;
      req_in[s].wdata = $urandom;
      req_in[s].raddr = $urandom;
      rd_in[s]        = $urandom;
    end
    req_vld_in = rqv;
    rd_vld_in  = rdv;
    push_expect();
  endtask

  // Idle until the cycle a beat driven in the current cycle appears, then sit at its negedge.
  task automatic wait_due();
    idle(L);
    @(negedge clk);
  endtask

  task automatic do_cfg();
    bit seen;
    tick();
    req_vld_in = '0;
    rd_vld_in  = '0;
    for (int d = 0; d < P; d++) begin
      cfg_wsel[d] = nw[d];
      cfg_rsel[d] = nr[d];
    end
    cfg_valid = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) check("quiesce_before", 128'(quiesce), 128'(0));
      if (i == 1) check("quiesce_after_cfg", 128'(quiesce), 128'(1));
      if (cfg_ready) seen = 1'b1;
    end
    if (!seen) fail_now("cfg_ready_timeout");
    else begin
      check("swap_state", 128'(dbg_state), 128'(SWAP));
      check("swap_not_busy", 128'(busy), 128'(0));
      check("swap_after_drain", 128'(req_q.size() + rd_q.size()), 128'(0));
    end
    tick();
    cfg_valid = 1'b0;
    if (seen) begin
      check("cfg_ready_one_cycle", 128'(cfg_ready), 128'(0));
      for (int d = 0; d < P; d++) begin
        mw[d] = nw[d];
        mr[d] = nr[d];
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    req_in = '0; req_vld_in = '0; rd_in = '0; rd_vld_in = '0;
    cfg_valid = 1'b0; cfg_wsel = '0; cfg_rsel = '0;
    for (int d = 0; d < P; d++) begin mw[d] = 3'd4; mr[d] = 3'd4; end

    // reset state
    repeat (3) tick();
    for (int d = 0; d < P; d++) begin
      check("rst_req_out", 128'(req_out[d]), 128'(0));
      check("rst_rd_out", 128'(rd_out[d]), 128'(0));
    end
    check("rst_req_vld", 128'(req_vld_out), 128'(0));
    check("rst_rd_vld", 128'(rd_vld_out), 128'(0));
    check("rst_cfg_ready", 128'(cfg_ready), 128'(0));
    check("rst_quiesce", 128'(quiesce), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_sel_err", 128'(sel_err), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(RUN));
    rst = 1'b0;

    // 1: RAM k takes module 3-k; module 0 writes 0x10/0xA5 and lands on RAM 3
    for (int d = 0; d < P; d++) begin nw[d] = route_t'(3 - d); nr[d] = route_t'(d); end
    do_cfg();
    tick();
    req_in[0].wren = 1'b1; req_in[0].waddr = 32'h10; req_in[0].wdata = 32'hA5; req_in[0].raddr = '0;
    req_vld_in = 4'b0001;
    push_expect();
    wait_due();
    check("t1_vld_only_ram3", 128'(req_vld_out), 128'(4'b1000));
    check("t1_waddr", 128'(req_out[3].waddr), 128'(32'h10));
    check("t1_wdata", 128'(req_out[3].wdata), 128'(32'hA5));

    // 2: broadcast module... read source 1 to every module
    for (int d = 0; d < P; d++) nr[d] = 3'd1;
    do_cfg();
    tick();
    rd_in[1] = 32'hDEAD;
    rd_vld_in = 4'b0010;
    push_expect();
    wait_due();
    check("t2_broadcast_vld", 128'(rd_vld_out), 128'(4'b1111));

    // 3: reconfigure with two beats in flight; beats exit on the old routes first
    for (int d = 0; d < P; d++) begin nw[d] = route_t'(d); nr[d] = route_t'((d + 1) % P); end
    rand_cycle(4'hf, 4'hf);
    rand_cycle(4'hf, 4'hf);
    do_cfg();
    rand_cycle(4'hf, 4'hf);
    idle(L + 2);

    // 4: out-of-range route code 5 on RAM 2 is flagged and never drives valid
    nw[2] = 3'd5;
    do_cfg();
    @(negedge clk);
    check("t4_sel_err_set", 128'(sel_err), 128'(1));
    rand_cycle(4'hf, 4'hf);
    wait_due();
    check("t4_ram2_silent", 128'(req_vld_out[2]), 128'(0));
    for (int d = 0; d < P; d++) nw[d] = route_t'(d);
    do_cfg();
    @(negedge clk);
    check("t4_sel_err_sticky", 128'(sel_err), 128'(1));

    // 5: disabled routes output zero; an invalid beat never writes
    nw[1] = 3'd4;
    nr[2] = 3'd4;
    do_cfg();
    tick();
    req_in[0].wren = 1'b1; req_in[0].waddr = '1; req_in[0].wdata = '1;
    req_in[1].wren = 1'b1; req_in[1].waddr = '1; req_in[1].wdata = '1; req_in[1].raddr = '1;
    for (int s = 0; s < P; s++) rd_in[s] = '1;
    req_vld_in = 4'b0010;
    rd_vld_in  = 4'b1111;
    push_expect();
    wait_due();
    check("t5_invalid_beat_wren", 128'(req_out[0].wren), 128'(0));
    check("t5_disabled_req", 128'(req_out[1]), 128'(0));
    check("t5_disabled_rd", 128'(rd_out[2]), 128'(0));
    check("t5_disabled_rd_vld", 128'(rd_vld_out[2]), 128'(0));

    // random rounds against the route-table model
    for (int r = 0; r < 3; r++) begin
      for (int d = 0; d < P; d++) begin
        nw[d] = route_t'($urandom_range(0, 4));
        nr[d] = route_t'($urandom_range(0, 4));
      end
      do_cfg();
      for (int i = 0; i < 15; i++)
        rand_cycle(P'($urandom_range(0, 15)), P'($urandom_range(0, 15)));
      idle(L + 2);
    end

    // 6: asynchronous reset in DRAIN with a beat in flight
    for (int d = 0; d < P; d++) begin nw[d] = route_t'(d); nr[d] = route_t'(d); end
    do_cfg();
    rand_cycle(4'hf, 4'h0);
    cfg_valid = 1'b1;
    tick();
    req_vld_in = '0;
    #2;
    rst = 1'b1;
    req_q.delete();
    rd_q.delete();
    cfg_valid = 1'b0;
    #1;
    check("t6_req_vld_zero", 128'(req_vld_out), 128'(0));
    check("t6_rd_vld_zero", 128'(rd_vld_out), 128'(0));
    for (int d = 0; d < P; d++) check("t6_req_out_zero", 128'(req_out[d]), 128'(0));
    check("t6_busy_zero", 128'(busy), 128'(0));
    check("t6_quiesce_zero", 128'(quiesce), 128'(0));
    tick();
    tick();
    rst = 1'b0;
    for (int d = 0; d < P; d++) begin mw[d] = 3'd4; mr[d] = 3'd4; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_no_cfg_ready", 128'(cfg_ready), 128'(0));
    end
    check("t6_state_run", 128'(dbg_state), 128'(RUN));
    check("t6_busy_idle", 128'(busy), 128'(0));
    check("t6_sel_err_cleared", 128'(sel_err), 128'(0));
    rand_cycle(4'hf, 4'hf);
    idle(L + 3);
    check("final_req_queue_empty", 128'(req_q.size()), 128'(0));
    check("final_rd_queue_empty", 128'(rd_q.size()), 128'(0));

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
